// File: rtl/edge_detection_pkg.sv
// Shared constants and helpers for the edge-detection pipeline (3x3 window and Sobel stages).
package edge_detection_pkg;

    localparam int unsigned SUBPIXEL_DEPTH = 8;
    localparam int unsigned WINDOW_DIM     = 3;

    // LSB index of window element (r, c) in a flattened r-major window bus.
    function automatic int unsigned win_bit(input int unsigned r, input int unsigned c,
                                            input int unsigned depth);
        return (r * WINDOW_DIM + c) * depth;
    endfunction

endpackage

// File: rtl/line_buffer.sv
// Fixed-depth pixel delay line; the tail is the pixel pushed Depth shifts ago.
module line_buffer #(
    parameter int unsigned Depth = 640,
    parameter int unsigned Width = 8
) (
    input  logic             clk_i,
    input  logic             shift_i,
    input  logic [Width-1:0] pixel_i,
    output logic [Width-1:0] tail_o
);

    // Contents are intentionally not reset; they are only consumed once two rows are filled.
    logic [Width-1:0] mem_q [Depth];

    always_ff @(posedge clk_i) begin
        if (shift_i) begin
            mem_q[0] <= pixel_i;
            for (int unsigned i = 1; i < Depth; i++) begin
                mem_q[i] <= mem_q[i-1];
            end
        end
    end

    assign tail_o = mem_q[Depth-1];

endmodule

// File: rtl/window_3x3.sv
// Raster-order 3x3 neighbourhood generator: two line buffers feed a shifting window register,
// with position tracking so only fully in-frame windows are flagged valid.
module window_3x3
    import edge_detection_pkg::*;
#(
    parameter int unsigned P_SUBPIXEL_DEPTH = SUBPIXEL_DEPTH,
    parameter int unsigned P_IMAGE_WIDTH    = 640,
    parameter int unsigned P_IMAGE_HEIGHT   = 480
) (
    input  logic                                  I_CLK,
    input  logic                                  I_RESET,
    input  logic                                  I_ENABLE,
    input  logic                                  I_VALID,
    input  logic                                  I_SOF,
    input  logic [P_SUBPIXEL_DEPTH-1:0]           I_PIXEL,
    output logic [9*P_SUBPIXEL_DEPTH-1:0]         O_WINDOW,
    output logic                                  O_VALID,
    output logic                                  O_EOF
);

    localparam int unsigned D  = P_SUBPIXEL_DEPTH;
    localparam int unsigned CW = $clog2(P_IMAGE_WIDTH);
    localparam int unsigned RW = $clog2(P_IMAGE_HEIGHT);

    localparam logic [CW-1:0] ColLast       = CW'(P_IMAGE_WIDTH - 1);
    localparam logic [RW-1:0] RowLast       = RW'(P_IMAGE_HEIGHT - 1);
    localparam logic [CW-1:0] ColFirstValid = CW'(WINDOW_DIM - 1);
    localparam logic [RW-1:0] RowFirstValid = RW'(WINDOW_DIM - 1);

    logic          accept;
    logic [CW-1:0] col_q, col_d, col_pos;
    logic [RW-1:0] row_q, row_d, row_pos;
    logic          valid_q, valid_d;
    logic          eof_q, eof_d;
    logic          at_col_end, at_row_end;

    logic [D-1:0] line1_tail, line2_tail;
    logic [D-1:0] col_new [WINDOW_DIM];
    logic [D-1:0] win_q   [WINDOW_DIM][WINDOW_DIM];
    logic [D-1:0] win_d   [WINDOW_DIM][WINDOW_DIM];

    line_buffer #(
        .Depth (P_IMAGE_WIDTH),
        .Width (D)
    ) u_line1 (
        .clk_i   (I_CLK),
        .shift_i (accept),
        .pixel_i (I_PIXEL),
        .tail_o  (line1_tail)
    );

    line_buffer #(
        .Depth (P_IMAGE_WIDTH),
        .Width (D)
    ) u_line2 (
        .clk_i   (I_CLK),
        .shift_i (accept),
        .pixel_i (line1_tail),
        .tail_o  (line2_tail)
    );

    always_comb begin
        accept     = I_ENABLE & I_VALID;
        // SOF relocates the accepted pixel to the frame origin.
        col_pos    = I_SOF ? '0 : col_q;
        row_pos    = I_SOF ? '0 : row_q;
        at_col_end = (col_pos == ColLast);
        at_row_end = (row_pos == RowLast);

        col_d   = col_q;
        row_d   = row_q;
        valid_d = valid_q;
        eof_d   = eof_q;

        if (accept) begin
            col_d   = at_col_end ? '0 : col_pos + CW'(1);
            row_d   = at_col_end ? (at_row_end ? '0 : row_pos + RW'(1)) : row_pos;
            valid_d = (col_pos >= ColFirstValid) && (row_pos >= RowFirstValid);
            eof_d   = at_col_end && at_row_end;
        end else if (I_ENABLE) begin
            valid_d = 1'b0;
            eof_d   = 1'b0;
        end
    end

    always_comb begin
        col_new[0] = line2_tail;
        col_new[1] = line1_tail;
        col_new[2] = I_PIXEL;
        win_d      = win_q;
        if (accept) begin
            for (int unsigned r = 0; r < WINDOW_DIM; r++) begin
                for (int unsigned c = 0; c < WINDOW_DIM - 1; c++) begin
                    win_d[r][c] = win_q[r][c+1];
                end
                win_d[r][WINDOW_DIM-1] = col_new[r];
            end
        end
    end

    always_ff @(posedge I_CLK or posedge I_RESET) begin
        if (I_RESET) begin
            col_q   <= '0;
            row_q   <= '0;
            valid_q <= 1'b0;
            eof_q   <= 1'b0;
            for (int unsigned r = 0; r < WINDOW_DIM; r++) begin
                for (int unsigned c = 0; c < WINDOW_DIM; c++) begin
                    win_q[r][c] <= '0;
                end
            end
        end else begin
            col_q   <= col_d;
            row_q   <= row_d;
            valid_q <= valid_d;
            eof_q   <= eof_d;
            win_q   <= win_d;
        end
    end

    always_comb begin
        O_WINDOW = '0;
        for (int unsigned r = 0; r < WINDOW_DIM; r++) begin
            for (int unsigned c = 0; c < WINDOW_DIM; c++) begin
                O_WINDOW[win_bit(r, c, D) +: D] = win_q[r][c];
            end
        end
    end

    assign O_VALID = valid_q;
    assign O_EOF   = eof_q;

endmodule

// File: tb/tb_window_3x3.sv
// Directed bench for window_3x3 on a 5x4 image with pixel value row*16+col.
module tb_window_3x3;

    localparam int W = 5;
    localparam int H = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        en, vld, sof;
    logic [7:0]  pix;
    logic [71:0] win;
    logic        ovalid, oeof;

    int tests = 0;
    int fails = 0;

    window_3x3 #(
        .P_SUBPIXEL_DEPTH (8),
        .P_IMAGE_WIDTH    (W),
        .P_IMAGE_HEIGHT   (H)
    ) dut (
        .I_CLK    (clk),
        .I_RESET  (rst),
        .I_ENABLE (en),
        .I_VALID  (vld),
        .I_SOF    (sof),
        .I_PIXEL  (pix),
        .O_WINDOW (win),
        .O_VALID  (ovalid),
        .O_EOF    (oeof)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] p, input logic s, input logic v, input logic e);
        pix = p;
        sof = s;
        vld = v;
        en  = e;
        @(posedge clk);
        #1;
    endtask

    // Window centred at (r-1, c-1) for the reference image.
    function automatic logic [71:0] exp_win(input int r, input int c);
        logic [71:0] w;
        w = '0;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                w[(i*3+j)*8 +: 8] = 8'((r - 2 + i) * 16 + (c - 2 + j));
            end
        end
        return w;
    endfunction

    task automatic stream_frame(input string name, input bit sof_first, input bit bubbles,
                                input int stall_r, input int stall_c);
        int          nvalid;
        logic        ev, ee;
        logic [71:0] ew;
        nvalid = 0;
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                push(8'(r * 16 + c), sof_first && r == 0 && c == 0, 1'b1, 1'b1);
                ev = (r >= 2) && (c >= 2);
                ee = (r == H - 1) && (c == W - 1);
                ew = exp_win(r, c);
                nvalid += int'(ovalid);
                check($sformatf("%s valid r%0d c%0d", name, r, c), 72'(ovalid), 72'(ev));
                check($sformatf("%s eof r%0d c%0d", name, r, c), 72'(oeof), 72'(ee));
                if (ev) check($sformatf("%s win r%0d c%0d", name, r, c), win, ew);
                if (r == stall_r && c == stall_c) begin
                    for (int k = 0; k < 3; k++) begin
                        push(8'hEE, 1'b1, 1'b1, 1'b0);
                        check($sformatf("%s stall%0d valid", name, k), 72'(ovalid), 72'(ev));
                        check($sformatf("%s stall%0d eof", name, k), 72'(oeof), 72'(ee));
                        check($sformatf("%s stall%0d win", name, k), win, ew);
                    end
                end
                if (bubbles) begin
                    // SOF on a bubble must be ignored.
                    push(8'hBB, 1'b1, 1'b0, 1'b1);
                    check($sformatf("%s bubble valid r%0d c%0d", name, r, c), 72'(ovalid), 72'(0));
                    check($sformatf("%s bubble eof r%0d c%0d", name, r, c), 72'(oeof), 72'(0));
                end
            end
        end
        check($sformatf("%s window count", name), 72'(nvalid), 72'(6));
    endtask

    initial begin
        logic [71:0] ew;
        rst = 1'b1;
        en  = 1'b0;
        vld = 1'b0;
        sof = 1'b0;
        pix = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset valid", 72'(ovalid), 72'(0));
        check("reset eof", 72'(oeof), 72'(0));
        check("reset win", win, 72'(0));
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Frame 1 with SOF, frame 2 back to back (natural wrap) with a stall while valid.
        stream_frame("f1", 1'b1, 1'b0, -1, -1);
        stream_frame("f2", 1'b0, 1'b0, 2, 3);
        // Frame 3: SOF coincides with natural wrap, bubbles everywhere, stall on the EOF window.
        stream_frame("f3", 1'b1, 1'b1, 3, 4);

        // Mid-frame SOF at pixel (2,3).
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < W; c++) begin
                if (r == 2 && c == 3) break;
                push(8'(r * 16 + c), r == 0 && c == 0, 1'b1, 1'b1);
            end
        end
        check("presof valid", 72'(ovalid), 72'(1));
        check("presof win", win, exp_win(2, 2));
        push(8'h23, 1'b1, 1'b1, 1'b1);
        check("sof valid", 72'(ovalid), 72'(0));
        for (int n = 1; n <= 12; n++) begin
            int r, c;
            r = n / W;
            c = n % W;
            push(8'(r * 16 + c), 1'b0, 1'b1, 1'b1);
            check($sformatf("postsof valid n%0d", n), 72'(ovalid), 72'(n == 12));
        end
        ew = exp_win(2, 2);
        ew[7:0] = 8'h23;
        check("postsof win", win, ew);
        check("postsof eof", 72'(oeof), 72'(0));

        // Asynchronous reset in the middle of row 2.
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < W; c++) begin
                if (r == 2 && c == 4) break;
                push(8'(r * 16 + c), r == 0 && c == 0, 1'b1, 1'b1);
            end
        end
        check("prerst valid", 72'(ovalid), 72'(1));
        check("prerst win", win, exp_win(2, 3));
        #2;
        rst = 1'b1;
        #1;
        check("async rst valid", 72'(ovalid), 72'(0));
        check("async rst eof", 72'(oeof), 72'(0));
        check("async rst win", win, 72'(0));
        vld = 1'b0;
        sof = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        stream_frame("f4", 1'b0, 1'b0, -1, -1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/window_3x3.md
# window_3x3

Downstream neighbour of the grayscale converter: accepts one grayscale pixel per cycle in raster order and produces the 3x3 neighbourhood each Sobel edge-detection stage consumes. It keeps two previous image rows in line buffers, tracks row and column position, and flags a window valid only when all nine pixels belong to the current frame. Image borders produce no valid window.

## Interface
- P_SUBPIXEL_DEPTH, 8, bits per grayscale pixel
- P_IMAGE_WIDTH, 640, pixels per row, minimum 3
- P_IMAGE_HEIGHT, 480, rows per frame, minimum 3
- I_CLK  input  1  clock
- I_RESET  input  1  reset, asynchronous, active-high
- I_ENABLE  input  1  global stall; 0 freezes all state and outputs
- I_VALID  input  1  I_PIXEL carries a pixel this cycle
- I_SOF  input  1  start of frame; qualified by I_ENABLE & I_VALID
- I_PIXEL  input  P_SUBPIXEL_DEPTH  grayscale pixel
- O_WINDOW  output  9*P_SUBPIXEL_DEPTH  element k=r*3+c at bits [k*D +: D]; r=0 is the oldest row (top), c=0 is the oldest column (left)
- O_VALID  output  1  O_WINDOW is a complete in-frame neighbourhood
- O_EOF  output  1  with O_VALID: last window of the frame

## Operation
- Accept occurs when I_ENABLE=1 and I_VALID=1. Every state change in the block happens only on an accept, except O_VALID/O_EOF clearing.
- Position counters col (0..W-1) and row (0..H-1) give the location of the pixel being accepted.
  - When col=W-1, col wraps to 0 and row increments.
  - When row=H-1 and col=W-1, both counters wrap to 0.
- I_SOF=1 on an accept forces that pixel to position (0,0). The counters then continue from (0,1). A partial frame in progress is abandoned.
- Line buffers:
  - line1 is a W-deep shift register holding the previous row.
  - line2 is a W-deep shift register holding the row before that.
  - On accept, line1 takes I_PIXEL, line2 takes line1's tail, and both advance.
- Window registers:
  - A 3x3 array shifts left on accept.
  - The new right column is {line2 tail (r=0), line1 tail (r=1), I_PIXEL (r=2)}.
- O_VALID is registered. It becomes 1 after an accept at col>=2 and row>=2, with the window centred at (row-1, col-1). It becomes 0 after an enabled cycle with no accept.
- O_EOF is registered. It becomes 1 together with O_VALID when the accepted pixel is at (H-1, W-1); otherwise it is 0.
- Window counts:
  - Windows per frame = (W-2)*(H-2).
  - Columns 0 and 1 never produce a valid window, because the window would wrap across rows.
  - Rows 0 and 1 never produce a valid window.
- Arithmetic: counters are $clog2(W) and $clog2(H) bits wide. No pixel arithmetic happens in this block.

## Timing
- Latency: 1 cycle from accept to O_WINDOW/O_VALID.
- Throughput: 1 pixel per cycle, with no backpressure output.
- Reset (asynchronous, at any time):
  - col=0, row=0.
  - Window registers = 0, so O_WINDOW=0.
  - O_VALID=0, O_EOF=0.
  - Line buffer contents are not reset; they are don't-care until row 2.
- Reset mid-frame: the next accepted pixel is treated as (0,0) whether or not I_SOF is set.
- I_ENABLE=0: all registers hold, including O_VALID and O_EOF. I_ENABLE has priority over I_VALID and I_SOF.
- I_SOF on the same accept as a natural wrap to (0,0): identical result, no error.
- I_SOF with I_VALID=0: ignored.

## Structure
- Shared package/include edge_detection_pkg holds:
  - the subpixel depth default (8)
  - the window dimension constant (3)
  - the window bit-index helper used by this block and the Sobel stage.
- Sub-module line_buffer:
  - parameters depth and width
  - ports: shift enable, input pixel, tail output
  - instantiated twice
  - may later be swapped for SRAM macros without changing window_3x3.

## Test plan
Parameters for all scenarios: W=5, H=4. Stimulus pixel value = row*16+col.
- Full frame streamed continuously, I_SOF on the first pixel -> exactly 6 O_VALID pulses, first one the cycle after accepting 0x22, with O_WINDOW rows {00,01,02}/{10,11,12}/{20,21,22}. The last window is {12,13,14}/{22,23,24}/{32,33,34} with O_EOF=1.
- I_VALID=0 every other cycle across the frame -> same 6 windows and values; O_VALID is 0 on every cycle following a bubble.
- I_ENABLE=0 for 3 cycles while O_VALID=1 -> O_WINDOW, O_VALID and O_EOF held unchanged; streaming resumes with no lost or duplicated window.
- Second frame back to back, no I_SOF -> counters wrap naturally and the first window again appears after pixel (2,2), with no valid window at cols 0-1 of any row.
- I_SOF asserted at mid-frame pixel (2,3) -> that pixel is treated as (0,0) and the next valid window appears only after 12 further accepted pixels.
- I_RESET pulsed asynchronously mid-row 2 -> O_VALID, O_EOF and O_WINDOW go to 0 immediately; the next frame restarts at (0,0) and produces 6 correct windows.
